// File: rtl/byte_bcd_display_scanner.sv
// Byte-to-BCD converter (iterative double-dabble) feeding a three-digit
// multiplexed 7-segment scanner with optional leading-zero blanking.
module byte_bcd_display_scanner #(
  parameter int REFRESH_DIV       = 50000,
  parameter bit BLANK_LEADING     = 1'b1,
  parameter bit ENABLE_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] byte_in,
  input  logic       byte_valid,
  output logic       byte_ready,
  output logic       conv_done,
  output logic [3:0] digit_bcd,
  output logic [2:0] digit_en
);

  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(REFRESH_DIV - 1);
  localparam logic [3:0] BLANK_CODE = 4'hF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  state_t            state_r, state_s;
  logic [19:0]       shift_r, shift_s;
  logic [2:0]        iter_r, iter_s;
  logic              commit_s;
  logic [3:0]        hund_r, tens_r, ones_r;
  logic              conv_done_r;
  logic [DIV_W-1:0]  div_r;
  logic [1:0]        slot_r;
  logic [3:0]        digit_s, digit_bcd_r;
  logic [2:0]        en_onehot_s, digit_en_r;

  // One double-dabble iteration: correct each BCD nibble >= 5, then shift left.
  function automatic logic [19:0] dabble_step(input logic [19:0] sr);
    logic [19:0] adj;
    adj = sr;
    for (int i = 0; i < 3; i++) begin
      if (adj[8+4*i +: 4] >= 4'd5) begin
        adj[8+4*i +: 4] = adj[8+4*i +: 4] + 4'd3;
      end else begin
        adj[8+4*i +: 4] = adj[8+4*i +: 4];
      end
    end
    return {adj[18:0], 1'b0};
  endfunction

  assign byte_ready = (state_r == IDLE);
  assign conv_done  = conv_done_r;
  assign digit_bcd  = digit_bcd_r;
  assign digit_en   = digit_en_r;

  // FSM state and conversion datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      shift_r <= 20'd0;
      iter_r  <= 3'd0;
    end else begin
      state_r <= state_s;
      shift_r <= shift_s;
      iter_r  <= iter_s;
    end
  end

  // FSM next-state and datapath next values
  always_comb begin
    state_s  = state_r;
    shift_s  = shift_r;
    iter_s   = iter_r;
    commit_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (byte_valid) begin
          state_s = SHIFT;
          shift_s = {12'd0, byte_in};
          iter_s  = 3'd0;
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        shift_s = dabble_step(shift_r);
        iter_s  = iter_r + 3'd1;
        if (iter_r == 3'd7) begin
          state_s = COMMIT;
        end else begin
          state_s = SHIFT;
        end
      end
      COMMIT: begin
        commit_s = 1'b1;
        state_s  = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Display registers and the commit pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hund_r      <= 4'd0;
      tens_r      <= 4'd0;
      ones_r      <= 4'd0;
      conv_done_r <= 1'b0;
    end else begin
      conv_done_r <= commit_s;
      if (commit_s) begin
        hund_r <= shift_r[19:16];
        tens_r <= shift_r[15:12];
        ones_r <= shift_r[11:8];
      end
    end
  end

  // Refresh divider and slot rotation, free-running
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_r  <= '0;
      slot_r <= 2'd0;
    end else if (div_r == DIV_MAX) begin
      div_r  <= '0;
      slot_r <= (slot_r == 2'd2) ? 2'd0 : slot_r + 2'd1;
    end else begin
      div_r <= div_r + DIV_W'(1);
    end
  end

  // Digit selection with leading-zero blanking
  always_comb begin
    digit_s     = ones_r;
    en_onehot_s = 3'b001;
    case (slot_r)
      2'd0: begin
        digit_s     = ones_r;
        en_onehot_s = 3'b001;
      end
      2'd1: begin
        if (BLANK_LEADING && (hund_r == 4'd0) && (tens_r == 4'd0)) begin
          digit_s = BLANK_CODE;
        end else begin
          digit_s = tens_r;
        end
        en_onehot_s = 3'b010;
      end
      2'd2: begin
        if (BLANK_LEADING && (hund_r == 4'd0)) begin
          digit_s = BLANK_CODE;
        end else begin
          digit_s = hund_r;
        end
        en_onehot_s = 3'b100;
      end
      default: begin
        digit_s     = ones_r;
        en_onehot_s = 3'b001;
      end
    endcase
  end

  // Registered display outputs; bus and enable always move together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_bcd_r <= 4'd0;
      digit_en_r  <= ENABLE_ACTIVE_LOW ? 3'b110 : 3'b001;
    end else begin
      digit_bcd_r <= digit_s;
      digit_en_r  <= ENABLE_ACTIVE_LOW ? ~en_onehot_s : en_onehot_s;
    end
  end

endmodule

// File: tb/tb_byte_bcd_display_scanner.sv
// Directed bench: one blanking and one non-blanking instance share stimulus;
// expected digits come from integer division on the byte value.
module tb_byte_bcd_display_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] byte_in;
  logic       byte_valid;
  logic       ready_a, done_a, ready_b, done_b;
  logic [3:0] bcd_a, bcd_b;
  logic [2:0] en_a, en_b;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  byte_bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b1), .ENABLE_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(ready_a), .conv_done(done_a), .digit_bcd(bcd_a), .digit_en(en_a)
  );

  byte_bcd_display_scanner #(.REFRESH_DIV(4), .BLANK_LEADING(1'b0), .ENABLE_ACTIVE_LOW(1'b1)) dut_nb (
    .clk(clk), .rst_n(rst_n), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(ready_b), .conv_done(done_b), .digit_bcd(bcd_b), .digit_en(en_b)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int slot_of(input logic [2:0] en);
    case (en)
      3'b110:  return 0;
      3'b101:  return 1;
      3'b011:  return 2;
      default: return 3;
    endcase
  endfunction

  function automatic int exp_digit(input int v, input int slot, input bit blank);
    int h, t, o;
    h = v / 100;
    t = (v / 10) % 10;
    o = v % 10;
    case (slot)
      0:       return o;
      1:       return (blank && h == 0 && t == 0) ? 15 : t;
      2:       return (blank && h == 0) ? 15 : h;
      default: return -1;
    endcase
  endfunction

  // Sample n scan cycles and check each shown digit against value v.
  task automatic scan_check(input int v, input int n);
    int sa, sb;
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      sa = slot_of(en_a);
      sb = slot_of(en_b);
      check("scan_en_valid", (sa < 3) ? 1 : 0, 1);
      check("scan_digit_blank", bcd_a, exp_digit(v, sa, 1'b1));
      check("scan_digit_noblank", bcd_b, exp_digit(v, sb, 1'b0));
    end
  endtask

  // Present one byte and follow it through to the commit pulse.
  task automatic send_byte(input int v);
    int lat, low;
    @(negedge clk);
    check("ready_idle", ready_a, 1);
    byte_in    = 8'(v);
    byte_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    low = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      byte_valid = 1'b0;
      if (!ready_a) low++;
      if (done_a) begin
        lat = k;
        break;
      end
    end
    check("conv_latency", lat, 10);
    check("ready_low_cycles", low, 9);
    check("done_noblank", done_b, 1);
    @(negedge clk);
    check("done_pulse_width", done_a, 0);
    check("ready_after_commit", ready_a, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acc, extra, seen, es;
    rst_n      = 1'b0;
    byte_valid = 1'b0;
    byte_in    = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_ready", ready_a, 1);
    check("rst_done", done_a, 0);
    check("rst_bcd", bcd_a, 0);
    check("rst_en", en_a, 3'b110);
    check("rst_en_noblank", en_b, 3'b110);
    rst_n = 1'b1;

    // Idle scan after reset: each slot held for 4 cycles.
    for (int i = 1; i <= 24; i++) begin
      @(negedge clk);
      es = ((i - 1) / 4) % 3;
      check("idle_scan_en", en_a, (es == 0) ? 3'b110 : (es == 1) ? 3'b101 : 3'b011);
      check("idle_scan_bcd", bcd_a, (es == 0) ? 0 : 15);
      check("idle_scan_bcd_noblank", bcd_b, 0);
      check("idle_ready", ready_a, 1);
    end

    send_byte(255);
    scan_check(255, 12);
    send_byte(7);
    scan_check(7, 12);
    send_byte(40);
    scan_check(40, 12);

    // Back-to-back: valid held high, data switches to 99 after the first accept.
    @(negedge clk);
    byte_in    = 8'd100;
    byte_valid = 1'b1;
    @(posedge clk);
    acc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      byte_in = 8'd99;
      if (ready_a) begin
        acc = k;
        break;
      end
    end
    check("b2b_accept_gap", acc, 10);
    check("b2b_first_done", done_a, 1);
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    check("b2b_second_accepted", ready_a, 0);
    check("b2b_done_pulse", done_a, 0);
    scan_check(100, 8);
    acc = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (done_a) begin
        acc = k;
        break;
      end
    end
    check("b2b_second_done", acc, 1);
    extra = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (done_a) extra++;
    end
    check("b2b_no_duplicate", extra, 0);
    check("b2b_ready_idle", ready_a, 1);
    scan_check(99, 12);

    // Reset four cycles into a conversion of 123.
    @(negedge clk);
    byte_in    = 8'd123;
    byte_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    byte_valid = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    seen  = 0;
    @(negedge clk);
    check("midrst_ready", ready_a, 1);
    check("midrst_en", en_a, 3'b110);
    check("midrst_bcd", bcd_a, 0);
    repeat (2) begin
      @(negedge clk);
      if (done_a || done_b) seen++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("postrst_slot0_en", en_a, 3'b110);
    check("postrst_bcd", bcd_a, 0);
    check("postrst_ready", ready_a, 1);
    for (int k = 0; k < 15; k++) begin
      @(negedge clk);
      if (done_a || done_b) seen++;
    end
    check("postrst_no_done", seen, 0);
    scan_check(0, 12);

    // Full sweep of all byte values.
    for (int v = 0; v < 256; v++) begin
      send_byte(v);
      scan_check(v, 9);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
